jtpang_objdma: RTL and testbench

- Object DMA sequencer for the Pang/Super Pang main board.
- An I/O access to port 6 (`dma_go`) asks it to copy the object attribute area of the video RAM into the object line buffer's private RAM.
- It takes the Z80 bus with the BUSRQ/BUSAK handshake, streams `LEN` bytes at the `cen` rate, then hands the bus back.
- It sits between the main CPU wrapper (`busrq_n`/`busak_n`) and the video RAM / object buffer.

---
 rtl/jtpang_objdma.sv | 123 ++++++++++++
 tb/tb_jtpang_objdma.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_objdma.sv
// Object DMA sequencer: on a dma_go edge it takes the Z80 bus and copies LEN
// bytes of object attribute RAM into the object buffer, one byte per cen.
module jtpang_objdma #(
  parameter int              AW       = 12,
  parameter int              LEN      = 512,
  parameter logic [AW-1:0]   SRC_BASE = '0,
  parameter int              WAIT_VB  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq_n,
  output logic [AW-1:0] src_addr,
  output logic          src_cs,
  input  logic [7:0]    src_dout,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          buf_we,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VBWAIT = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_XFER   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_REL    = 3'd5;

  // Counter is one bit wider than AW so a full 2^AW transfer can be counted.
  localparam logic [AW:0] LEN_C  = (AW+1)'(LEN);
  localparam logic [AW:0] LAST_C = (AW+1)'(LEN - 1);

  logic [2:0]    state_q;
  logic          go_q;
  logic          busak_q;
  logic          pend_q;
  logic [AW:0]   cnt_q;
  logic          rd_q;
  logic [AW-1:0] rd_idx_q;
  logic          go_rise_d;

  assign go_rise_d = dma_go & ~go_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      busak_q  <= 1'b1;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      rd_idx_q <= '0;
      busrq_n  <= 1'b1;
      src_addr <= SRC_BASE;
      src_cs   <= 1'b0;
      buf_addr <= '0;
      buf_din  <= 8'd0;
      buf_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      go_q    <= dma_go;
      busak_q <= busak_n;
      src_cs  <= 1'b0;
      buf_we  <= 1'b0;
      done    <= 1'b0;
      rd_q    <= 1'b0;
      // Second half of a read: RAM data is valid one clk after the strobe.
      if (rd_q) begin
        buf_we   <= 1'b1;
        buf_addr <= rd_idx_q;
        buf_din  <= src_dout;
      end
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            pend_q  <= 1'b0;
            busy    <= 1'b1;
            state_q <= (WAIT_VB != 0) ? S_VBWAIT : S_REQ;
          end
        end
        S_VBWAIT: begin
          if (!LVBL) state_q <= S_REQ;
        end
        S_REQ: begin
          busrq_n <= 1'b0;
          if (!busak_q) begin
            state_q <= S_XFER;
            cnt_q   <= '0;
          end
        end
        S_XFER: begin
          // A withdrawn acknowledge freezes issue; an in-flight write still lands.
          if (cen && !busak_n && (cnt_q < LEN_C)) begin
            src_addr <= SRC_BASE + cnt_q[AW-1:0];
            src_cs   <= 1'b1;
            rd_q     <= 1'b1;
            rd_idx_q <= cnt_q[AW-1:0];
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST_C) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state_q <= S_REL;
        end
        S_REL: begin
          busrq_n <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Placed after the case so an edge in the accept cycle is not dropped.
      if (go_rise_d) pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: two instances (base 000 / base F80 with VB wait),
// a Z80 bus-grant model, a video RAM model and a transfer-level scoreboard.
module tb_jtpang_objdma;

  localparam int LEN = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       LVBL = 1'b1;
  logic [1:0] dma_go = 2'b00;
  logic [1:0] busak_n = 2'b11;
  logic [1:0] busrq_n, src_cs, buf_we, busy, done;
  logic [11:0] src_addr [2];
  logic [11:0] buf_addr [2];
  logic [7:0]  src_dout [2];
  logic [7:0]  buf_din  [2];

  int checks = 0;
  int errors = 0;
  int base_of [2] = '{0, 32'hF80};
  int rd_idx [2] = '{0, 0};
  int wr_idx [2] = '{0, 0};
  int nwr [2], ndone [2], ncs [2], rq_low [2];
  logic [7:0] bufmem [2][4096];
  logic [3:0] sr [2] = '{4'hF, 4'hF};
  logic [1:0] force_hi = 2'b00;
  int cen_div = 1;
  int cyc = 0;

  jtpang_objdma dut0 (
    .clk(clk), .rst(rst), .cen(cen), .LVBL(LVBL), .dma_go(dma_go[0]),
    .busak_n(busak_n[0]), .busrq_n(busrq_n[0]), .src_addr(src_addr[0]),
    .src_cs(src_cs[0]), .src_dout(src_dout[0]), .buf_addr(buf_addr[0]),
    .buf_din(buf_din[0]), .buf_we(buf_we[0]), .busy(busy[0]), .done(done[0])
  );

  jtpang_objdma #(.SRC_BASE(12'hF80), .WAIT_VB(1)) dut1 (
    .clk(clk), .rst(rst), .cen(cen), .LVBL(LVBL), .dma_go(dma_go[1]),
    .busak_n(busak_n[1]), .busrq_n(busrq_n[1]), .src_addr(src_addr[1]),
    .src_cs(src_cs[1]), .src_dout(src_dout[1]), .buf_addr(buf_addr[1]),
    .buf_din(buf_din[1]), .buf_we(buf_we[1]), .busy(busy[1]), .done(done[1])
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] vram(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Environment: cen pacing, Z80 grants 4 clk after busrq_n, RAM read data.
  always @(negedge clk) begin
    cyc++;
    cen = (cen_div == 1) ? 1'b1 : ((cyc % cen_div) == 0);
    for (int k = 0; k < 2; k++) begin
      sr[k] = {sr[k][2:0], busrq_n[k]};
      busak_n[k] = sr[k][3] | force_hi[k];
      src_dout[k] = vram(src_addr[k]);
    end
  end

  // Scoreboard: reads/writes must walk 0..LEN-1 in order, data from the RAM model.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rd_idx[k] = 0;
        wr_idx[k] = 0;
      end else begin
        if (src_cs[k]) begin
          chk("src_cs_gate", int'({cen, busak_n[k]}), 2);
          chk("src_addr", int'(src_addr[k]), (base_of[k] + rd_idx[k]) % 4096);
          chk("busy_rd", int'(busy[k]), 1);
          rd_idx[k]++;
          ncs[k]++;
        end
        if (buf_we[k]) begin
          chk("buf_addr", int'(buf_addr[k]), wr_idx[k]);
          chk("buf_din", int'(buf_din[k]), int'(vram(12'((base_of[k] + wr_idx[k]) % 4096))));
          bufmem[k][buf_addr[k]] = buf_din[k];
          wr_idx[k]++;
          nwr[k]++;
        end
        if (done[k]) begin
          chk("done_len", wr_idx[k], LEN);
          chk("done_rel", int'({busy[k], busrq_n[k]}), 1);
          rd_idx[k] = 0;
          wr_idx[k] = 0;
          ndone[k]++;
        end
        if (!busrq_n[k]) rq_low[k]++;
      end
    end
  end

  // driver tasks
  task automatic clr(input int k);
    nwr[k] = 0; ndone[k] = 0; ncs[k] = 0; rq_low[k] = 0;
    for (int i = 0; i < 4096; i++) bufmem[k][i] = ~vram(12'((base_of[k] + i) % 4096));
  endtask

  task automatic pulse_go(input int k);
    @(negedge clk) dma_go[k] = 1'b1;
    repeat (3) @(negedge clk);
    dma_go[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int target, input int maxc, input string nm);
    int c;
    c = 0;
    while (ndone[k] < target && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(nm, ndone[k], target);
  endtask

  task automatic wait_rd(input int k, input int n, input int maxc, input string nm);
    int c;
    c = 0;
    while (rd_idx[k] < n && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(nm, int'(rd_idx[k] >= n), 1);
  endtask

  task automatic buf_check(input int k, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (bufmem[k][i] != vram(12'((base_of[k] + i) % 4096))) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    int r0, r1, lowc;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_busrq0", int'(busrq_n[0]), 1);
    chk("rst_busrq1", int'(busrq_n[1]), 1);
    chk("rst_strobes", int'({src_cs, buf_we, busy, done}), 0);
    chk("rst_src0", int'(src_addr[0]), 0);
    chk("rst_src1", int'(src_addr[1]), 'hF80);
    chk("rst_buf", int'(buf_addr[0]) + int'(buf_din[0]), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // basic copy, cen every clk, grant 4 clk after request
    clr(0);
    pulse_go(0);
    wait_done(0, 1, 2000, "t1_done");
    repeat (20) @(negedge clk);
    chk("t1_nwr", nwr[0], 512);
    chk("t1_ndone", ndone[0], 1);
    chk("t1_rq_low", rq_low[0], 519);
    chk("t1_buf0", int'(bufmem[0][0]), 'h5A);
    chk("t1_buf511", int'(bufmem[0][511]), 'hA5);
    buf_check(0, "t1_buf");

    // cen 1-in-4, base F80 wrapping past FFF
    cen_div = 4;
    LVBL = 1'b0;
    clr(1);
    pulse_go(1);
    wait_done(1, 1, 5000, "t2_done");
    repeat (10) @(negedge clk);
    chk("t2_nwr", nwr[1], 512);
    chk("t2_ncs", ncs[1], 512);
    chk("t2_buf0", int'(bufmem[1][0]), 'hDA);
    chk("t2_buf128", int'(bufmem[1][128]), 'h5A);
    chk("t2_buf511", int'(bufmem[1][511]), 'h25);
    buf_check(1, "t2_buf");
    cen_div = 1;
    LVBL = 1'b1;

    // acknowledge withdrawn for 20 clk after byte 100
    clr(0);
    pulse_go(0);
    wait_rd(0, 101, 2000, "t3_reach100");
    force_hi[0] = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rd_idx[0];
    repeat (17) @(negedge clk);
    r1 = rd_idx[0];
    chk("t3_busrq_held", int'(busrq_n[0]), 0);
    force_hi[0] = 1'b0;
    chk("t3_gap_reads", r1, r0);
    chk("t3_byte100", int'(bufmem[0][100]), int'(vram(12'd100)));
    wait_done(0, 1, 2000, "t3_done");
    chk("t3_nwr", nwr[0], 512);
    buf_check(0, "t3_buf");
    repeat (10) @(negedge clk);

    // two further edges during a transfer merge into one extra transfer
    clr(0);
    pulse_go(0);
    wait_rd(0, 10, 2000, "t4_reach10");
    pulse_go(0);
    wait_rd(0, 300, 2000, "t4_reach300");
    pulse_go(0);
    wait_done(0, 2, 3000, "t4_done2");
    repeat (100) @(negedge clk);
    chk("t4_ndone", ndone[0], 2);
    chk("t4_nwr", nwr[0], 1024);
    buf_check(0, "t4_buf");

    // vertical-blank wait
    clr(1);
    LVBL = 1'b1;
    pulse_go(1);
    lowc = 0;
    repeat (50) begin
      @(negedge clk);
      if (!busrq_n[1]) lowc++;
    end
    chk("t5_no_req", lowc, 0);
    chk("t5_busy", int'(busy[1]), 1);
    LVBL = 1'b0;
    wait_done(1, 1, 2000, "t5_done");
    chk("t5_nwr", nwr[1], 512);
    buf_check(1, "t5_buf");
    LVBL = 1'b1;
    repeat (10) @(negedge clk);

    // reset at byte 200 with a request pending
    clr(0);
    pulse_go(0);
    wait_rd(0, 150, 2000, "t6_reach150");
    pulse_go(0);
    wait_rd(0, 200, 2000, "t6_reach200");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_busrq", int'(busrq_n[0]), 1);
    chk("t6_rst_busy", int'(busy[0]), 0);
    chk("t6_rst_strobes", int'({src_cs[0], buf_we[0], done[0]}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lowc = 0;
    repeat (40) begin
      @(negedge clk);
      if (!busrq_n[0]) lowc++;
    end
    chk("t6_pend_lost", lowc, 0);
    clr(0);
    pulse_go(0);
    wait_done(0, 1, 2000, "t6_done");
    chk("t6_nwr", nwr[0], 512);
    buf_check(0, "t6_buf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
